// File: rtl/controle_acumulador.sv
// Sequencer for an external accumulator: reads Qtd words starting at Base
// from a one-cycle-latency memory and strobes each one into the accumulator.
//
// Ports
//   Clock     rising-edge clock
//   Reset     asynchronous, active-low
//   Start     begin a run (only accepted while idle)
//   Base      first memory address of the run
//   Qtd       number of words to sum (clamped to 2^ENDERECOS)
//   Endereco  memory read address
//   Le        memory read enable (data on M one cycle later)
//   Load      accumulator input-register strobe
//   Transfer  accumulator result-register strobe
//   Clear     accumulator clear, active-low (also low while in reset)
//   Ocupado   run in progress
//   Pronto    one-cycle completion pulse
//
// All outputs are registered decodes of the current state, so each output
// lags its state by one cycle; Pronto therefore appears 4N+2 edges after the
// edge that accepts Start.
module controle_acumulador #(
   parameter int unsigned TAMANHO   = 16,
   parameter int unsigned ENDERECOS = 4
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   input  logic [ENDERECOS-1:0] Base,
   input  logic [ENDERECOS:0]   Qtd,
   output logic [ENDERECOS-1:0] Endereco,
   output logic                 Le,
   output logic                 Load,
   output logic                 Transfer,
   output logic                 Clear,
   output logic                 Ocupado,
   output logic                 Pronto
);

   localparam int unsigned AW = ENDERECOS;
   localparam int unsigned CW = ENDERECOS + 1;
   localparam logic [CW-1:0] QTD_MAX = {1'b1, {AW{1'b0}}};

   // Data width belongs to the downstream accumulator; only sanity-checked here.
   if (TAMANHO == 0) begin : g_tamanho_invalido
      $error("TAMANHO must be nonzero");
   end

   typedef enum logic [2:0] {
      OCIOSO,
      LIMPA,
      ENDERECA,
      ESPERA,
      CARREGA,
      TRANSFERE,
      FIM
   } estado_t;

   estado_t         estado, estado_prox;
   logic [AW-1:0]   addr, addr_prox;
   logic [CW-1:0]   cont, cont_prox;
   logic [AW-1:0]   endereco_prox;
   logic            le_prox, load_prox, transfer_prox;
   logic            clear_prox, ocupado_prox, pronto_prox;

   // State, run registers and registered outputs
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         estado   <= OCIOSO;
         addr     <= '0;
         cont     <= '0;
         Endereco <= '0;
         Le       <= 1'b0;
         Load     <= 1'b0;
         Transfer <= 1'b0;
         Clear    <= 1'b0;
         Ocupado  <= 1'b0;
         Pronto   <= 1'b0;
      end else begin
         estado   <= estado_prox;
         addr     <= addr_prox;
         cont     <= cont_prox;
         Endereco <= endereco_prox;
         Le       <= le_prox;
         Load     <= load_prox;
         Transfer <= transfer_prox;
         Clear    <= clear_prox;
         Ocupado  <= ocupado_prox;
         Pronto   <= pronto_prox;
      end
   end

   // Next state, run bookkeeping and output decode
   always_comb begin
      estado_prox   = estado;
      addr_prox     = addr;
      cont_prox     = cont;
      endereco_prox = Endereco;
      le_prox       = 1'b0;
      load_prox     = 1'b0;
      transfer_prox = 1'b0;
      clear_prox    = 1'b1;
      ocupado_prox  = 1'b1;
      pronto_prox   = 1'b0;

      case (estado)
         OCIOSO: begin
            ocupado_prox = 1'b0;
            if (Start) begin
               addr_prox   = Base;
               cont_prox   = (Qtd > QTD_MAX) ? QTD_MAX : Qtd;
               estado_prox = LIMPA;
            end
         end
         LIMPA: begin
            clear_prox  = 1'b0;
            estado_prox = (cont == '0) ? FIM : ENDERECA;
         end
         ENDERECA: begin
            le_prox       = 1'b1;
            endereco_prox = addr;
            estado_prox   = ESPERA;
         end
         ESPERA: begin
            estado_prox = CARREGA;
         end
         CARREGA: begin
            load_prox   = 1'b1;
            estado_prox = TRANSFERE;
         end
         TRANSFERE: begin
            transfer_prox = 1'b1;
            cont_prox     = cont - CW'(1);
            // Wraps silently past the top of the address space
            addr_prox     = addr + AW'(1);
            estado_prox   = (cont == CW'(1)) ? FIM : ENDERECA;
         end
         FIM: begin
            pronto_prox = 1'b1;
            estado_prox = OCIOSO;
         end
         default: begin
            estado_prox = OCIOSO;
         end
      endcase
   end

endmodule

// File: tb/tb_controle_acumulador.sv
// Directed bench for controle_acumulador with a one-cycle-latency memory
// and a behavioural accumulator driven by the DUT strobes.
module tb_controle_acumulador;

   localparam int unsigned TAMANHO   = 16;
   localparam int unsigned ENDERECOS = 4;

   logic                 Clock = 1'b0;
   logic                 Reset;
   logic                 Start;
   logic [ENDERECOS-1:0] Base;
   logic [ENDERECOS:0]   Qtd;
   logic [ENDERECOS-1:0] Endereco;
   logic                 Le, Load, Transfer, Clear, Ocupado, Pronto;

   logic [TAMANHO-1:0]   mem [16];
   logic [TAMANHO-1:0]   M;
   logic [TAMANHO-1:0]   in_reg;
   logic [TAMANHO-1:0]   acc;
   logic [ENDERECOS-1:0] addrs [$];

   int n_checks = 0;
   int n_fail   = 0;

   controle_acumulador #(.TAMANHO(TAMANHO), .ENDERECOS(ENDERECOS)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .Base     (Base),
      .Qtd      (Qtd),
      .Endereco (Endereco),
      .Le       (Le),
      .Load     (Load),
      .Transfer (Transfer),
      .Clear    (Clear),
      .Ocupado  (Ocupado),
      .Pronto   (Pronto)
   );

   always #5 Clock = ~Clock;

   // Memory: data appears on M one cycle after Le
   always @(posedge Clock) if (Le) M <= mem[Endereco];

   // Accumulator model
   always @(posedge Load) in_reg <= M;
   always @(posedge Transfer or negedge Clear)
      if (!Clear) acc <= '0;
      else        acc <= acc + in_reg;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Launch a run, observe it until Pronto, then check everything about it.
   // pulse_at > 0 raises Start (with junk Base/Qtd) during that cycle's state.
   task automatic run_and_check(input logic [3:0] b, input logic [4:0] q, input int n_exp,
                                input int pr_exp, input logic [15:0] acc_exp, input int pulse_at);
      int pr, n_le, n_ld, n_tr, n_clr, n_ovl, extra;
      logic [3:0] a_exp;
      @(negedge Clock);
      Base = b; Qtd = q; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0; Base = ~b; Qtd = ~q;
      pr = -1; n_le = 0; n_ld = 0; n_tr = 0; n_clr = 0; n_ovl = 0; extra = 0;
      addrs.delete();
      for (int k = 1; k <= 200; k++) begin
         @(posedge Clock); #1;
         if (Le) begin n_le++; addrs.push_back(Endereco); end
         if (Load) n_ld++;
         if (Transfer) n_tr++;
         if (!Clear) n_clr++;
         if (int'(Le) + int'(Load) + int'(Transfer) > 1) n_ovl++;
         if (k == pulse_at) begin Start = 1'b1; Base = 4'd9; Qtd = 5'd1; end
         if (k == pulse_at + 1) Start = 1'b0;
         if (Pronto) begin pr = k; break; end
      end
      check("pronto_cycle", 32'(pr), 32'(pr_exp));
      check("le_count", 32'(n_le), 32'(n_exp));
      check("load_count", 32'(n_ld), 32'(n_exp));
      check("transfer_count", 32'(n_tr), 32'(n_exp));
      check("clear_cycles", 32'(n_clr), 32'd1);
      check("strobe_overlap", 32'(n_ovl), 32'd0);
      check("addr_count", 32'(addrs.size()), 32'(n_exp));
      a_exp = b;
      foreach (addrs[i]) begin
         check("addr_seq", 32'(addrs[i]), 32'(a_exp));
         a_exp = a_exp + 4'd1;
      end
      check("acc_result", 32'(acc), 32'(acc_exp));
      for (int k = 0; k < 4; k++) begin
         @(posedge Clock); #1;
         if (Pronto) extra++;
      end
      check("pronto_single", 32'(extra), 32'd0);
      check("idle_ocupado", 32'(Ocupado), 32'd0);
   endtask

   initial begin : main
      int p1, p2, np;
      logic clr8;

      for (int i = 0; i < 16; i++) mem[i] = 16'(i * 5 + 2);
      mem[3] = 16'd1; mem[4] = 16'd2; mem[5] = 16'd3; mem[6] = 16'd4;

      // Reset values
      Reset = 1'b0; Start = 1'b0; Base = '0; Qtd = '0;
      #3;
      check("rst_clear", 32'(Clear), 32'd0);
      check("rst_ocupado", 32'(Ocupado), 32'd0);
      check("rst_strobes", 32'({Le, Load, Transfer, Pronto}), 32'd0);
      check("rst_endereco", 32'(Endereco), 32'd0);
      @(posedge Clock); #1;
      check("rst_clear_held", 32'(Clear), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      @(posedge Clock); #1;
      check("clear_release", 32'(Clear), 32'd1);

      // Base 3, four words 1+2+3+4
      run_and_check(4'd3, 5'd4, 4, 18, 16'd10, -1);
      // Empty run
      run_and_check(4'd7, 5'd0, 0, 2, 16'd0, -1);
      // Address wrap 14,15,0: 72+77+2
      run_and_check(4'd14, 5'd3, 3, 14, 16'd151, -1);
      // Qtd clamped to 16 words: whole memory
      run_and_check(4'd0, 5'd20, 16, 66, 16'd544, -1);
      // Start during CARREGA ignored
      run_and_check(4'd3, 5'd4, 4, 18, 16'd10, 3);

      // Reset in the second TRANSFERE aborts the run
      @(negedge Clock);
      Base = 4'd3; Qtd = 5'd4; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (8) @(posedge Clock);
      #1;
      check("pre_abort_ocupado", 32'(Ocupado), 32'd1);
      Reset = 1'b0;
      #1;
      check("abort_strobes", 32'({Le, Load, Transfer, Pronto}), 32'd0);
      check("abort_ocupado", 32'(Ocupado), 32'd0);
      check("abort_clear", 32'(Clear), 32'd0);
      check("abort_endereco", 32'(Endereco), 32'd0);
      np = 0;
      repeat (3) begin
         @(posedge Clock); #1;
         if (Pronto) np++;
      end
      check("abort_no_pronto", 32'(np), 32'd0);
      @(negedge Clock);
      Reset = 1'b1;
      // Recovery run: mem[5]+mem[6] = 3+4
      run_and_check(4'd5, 5'd2, 2, 10, 16'd7, -1);

      // Start held high: back-to-back runs
      @(negedge Clock);
      Base = 4'd0; Qtd = 5'd1; Start = 1'b1;
      @(posedge Clock); #1;
      p1 = -1; p2 = -1; clr8 = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge Clock); #1;
         if (k == 8) clr8 = Clear;
         if (k == 9) Start = 1'b0;
         if (Pronto) begin
            if (p1 < 0) p1 = k;
            else begin p2 = k; break; end
         end
      end
      check("held_pronto1", 32'(p1), 32'd6);
      check("held_restart_clear", 32'(clr8), 32'd0);
      check("held_pronto2", 32'(p2), 32'd13);
      check("held_acc", 32'(acc), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
